// File: rtl/bus_gate_arbiter_if.sv
// Bus-ownership handshake between the per-source request logic and the
// gate arbiter. The requester side drives arb_en/req; the arbiter side
// returns the registered gate vector plus status.
interface bus_gate_arbiter_if;
  logic       arb_en;
  logic [3:0] req;
  logic [3:0] gate;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  modport master (
    output arb_en,
    output req,
    input  gate,
    input  owner,
    input  busy,
    input  timeout
  );

  modport slave (
    input  arb_en,
    input  req,
    output gate,
    output owner,
    output busy,
    output timeout
  );
endinterface

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner sequencer for the shared 16-bit datapath bus.
// Bit order everywhere is {MARMUX, PC, ALU, MDR} = bit3..bit0.
// The gate vector comes straight from a register so the bus mux select
// never glitches. A released or timed-out owner drops to lowest priority.
module bus_gate_arbiter #(
  parameter int MAX_HOLD   = 8,
  parameter int CNT_W      = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  bus_gate_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [3:0]       r_gate;
  logic [1:0]       r_owner;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_holdCnt;
  logic             r_timeout;

  state_t           w_nextState;
  logic [3:0]       w_gate;
  logic [1:0]       w_owner;
  logic [1:0]       w_ptr;
  logic [CNT_W-1:0] w_holdCnt;
  logic             w_timeout;

  logic [3:0]       w_ownerHot;
  logic [1:0]       w_rotPtr;
  logic [2:0]       w_idlePick;
  logic [2:0]       w_handPick;
  logic             w_release;
  logic             w_expire;

  // Returns {found, index} of the first requester searching start,
  // start-1, ... with wrap; later loop passes are closer to start and win.
  function automatic logic [2:0] pickWinner(input logic [3:0] reqs,
                                            input logic [1:0] start);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start - 2'(i);
      if (reqs[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

  assign w_ownerHot = 4'b0001 << r_owner;
  assign w_rotPtr   = r_owner - 2'd1;
  assign w_idlePick = pickWinner(bus.req, r_ptr);
  assign w_handPick = pickWinner(bus.req & ~w_ownerHot, w_rotPtr);
  assign w_release  = ~bus.req[r_owner];
  assign w_expire   = (MAX_HOLD != 0) && (r_holdCnt == HOLD_LIMIT) && !w_release;

  // Next-state and next-grant decode; a release always wins over an expiry.
  always_comb begin
    w_nextState = r_state;
    w_gate      = r_gate;
    w_owner     = r_owner;
    w_ptr       = r_ptr;
    w_holdCnt   = r_holdCnt;
    w_timeout   = 1'b0;
    case (r_state)
      GRANT: begin
        if (w_release || w_expire) begin
          w_ptr     = w_rotPtr;
          w_timeout = w_expire;
          w_gate    = 4'b0000;
          w_holdCnt = '0;
          if (TURNAROUND != 0) begin
            w_nextState = TURN;
          end else if (bus.arb_en && w_handPick[2]) begin
            w_gate      = 4'b0001 << w_handPick[1:0];
            w_owner     = w_handPick[1:0];
            w_holdCnt   = HOLD_ONE;
            w_nextState = GRANT;
          end else begin
            w_nextState = IDLE;
          end
        end else if (r_holdCnt != HOLD_SAT) begin
          w_holdCnt = r_holdCnt + HOLD_ONE;
        end
      end
      default: begin
        w_gate      = 4'b0000;
        w_nextState = IDLE;
        if (bus.arb_en && w_idlePick[2]) begin
          w_gate      = 4'b0001 << w_idlePick[1:0];
          w_owner     = w_idlePick[1:0];
          w_holdCnt   = HOLD_ONE;
          w_nextState = GRANT;
        end
      end
    endcase
  end

  // State and output registers; reset clears the gate immediately.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_gate    <= 4'b0000;
      r_owner   <= 2'd0;
      r_ptr     <= 2'd3;
      r_holdCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_gate    <= w_gate;
      r_owner   <= w_owner;
      r_ptr     <= w_ptr;
      r_holdCnt <= w_holdCnt;
      r_timeout <= w_timeout;
    end
  end

  assign bus.gate    = r_gate;
  assign bus.owner   = r_owner;
  assign bus.busy    = |r_gate;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Bench for bus_gate_arbiter. Two instances run side by side:
// instance 0 with MAX_HOLD=4, CNT_W=3, TURNAROUND=1 and instance 1 with
// MAX_HOLD=8, CNT_W=4, TURNAROUND=0. A behavioural ownership model tracks
// each instance and is compared every cycle; directed scenarios add
// literal expectations.
module tb_bus_gate_arbiter;

  typedef struct {
    bit busy;
    int owner;
    int held;
    int ptr;
    bit to;
  } mstate_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] tbReq [2];
  logic       tbEn  [2];
  mstate_t    m     [2];
  int         nCompared = 0;
  int         nMismatched = 0;
  logic [3:0] expRot [9];
  logic [3:0] gotRot [9];

  bus_gate_arbiter_if bus0 ();
  bus_gate_arbiter_if bus1 ();

  assign bus0.req    = tbReq[0];
  assign bus0.arb_en = tbEn[0];
  assign bus1.req    = tbReq[1];
  assign bus1.arb_en = tbEn[1];

  bus_gate_arbiter #(.MAX_HOLD(4), .CNT_W(3), .TURNAROUND(1)) u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus0.slave)
  );

  bus_gate_arbiter #(.MAX_HOLD(8), .CNT_W(4), .TURNAROUND(0)) u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus1.slave)
  );

  always #5 Clk = ~Clk;

  function automatic int maxHoldOf(int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic int satOf(int k);
    return (k == 0) ? 7 : 15;
  endfunction

  function automatic int turnOf(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic mstate_t resetModel();
    mstate_t s;
    s.busy = 1'b0; s.owner = 0; s.held = 0; s.ptr = 3; s.to = 1'b0;
    return s;
  endfunction

  // First requester in the order p, p-1, ... wrapping; -1 if none.
  function automatic int pickModel(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (p - i + 4) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic mstate_t nextModel(mstate_t s, logic [3:0] r, logic en,
                                        int maxh, int sat, int ta);
    mstate_t n;
    int w;
    bit rel;
    bit expire;
    n = s;
    n.to = 1'b0;
    if (s.busy) begin
      rel = !r[s.owner];
      expire = !rel && (maxh != 0) && (s.held == maxh);
      if (rel || expire) begin
        n.to = expire;
        n.ptr = (s.owner + 3) % 4;
        n.busy = 1'b0;
        if (ta == 0) begin
          w = pickModel(r & ~(4'b0001 << s.owner), n.ptr);
          if (en && w >= 0) begin
            n.busy = 1'b1; n.owner = w; n.held = 1;
          end
        end
      end else begin
        n.held = (s.held < sat) ? s.held + 1 : sat;
      end
    end else begin
      w = pickModel(r, s.ptr);
      if (en && w >= 0) begin
        n.busy = 1'b1; n.owner = w; n.held = 1;
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] act,
                             input logic [3:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive both instances with the same inputs and move to the next negedge.
  task automatic applyStimulus(input logic [3:0] r, input logic en);
    tbReq[0] = r; tbReq[1] = r;
    tbEn[0]  = en; tbEn[1] = en;
    @(negedge Clk);
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    applyStimulus(4'b0000, 1'b1);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // Ownership model, advanced on every clock edge and cleared by reset.
  initial begin
    m[0] = resetModel();
    m[1] = resetModel();
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        m[0] = resetModel();
        m[1] = resetModel();
      end else begin
        for (int k = 0; k < 2; k++) begin
          m[k] = nextModel(m[k], tbReq[k], tbEn[k], maxHoldOf(k), satOf(k), turnOf(k));
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge Clk);
      begin
        logic [3:0] eg0, eg1;
        eg0 = m[0].busy ? (4'b0001 << m[0].owner) : 4'b0000;
        eg1 = m[1].busy ? (4'b0001 << m[1].owner) : 4'b0000;
        checkOutput("m0.gate", bus0.gate, eg0);
        checkOutput("m0.busy", {3'b000, bus0.busy}, {3'b000, m[0].busy});
        checkOutput("m0.timeout", {3'b000, bus0.timeout}, {3'b000, m[0].to});
        if (m[0].busy) checkOutput("m0.owner", {2'b00, bus0.owner}, 4'(m[0].owner));
        checkOutput("m1.gate", bus1.gate, eg1);
        checkOutput("m1.busy", {3'b000, bus1.busy}, {3'b000, m[1].busy});
        checkOutput("m1.timeout", {3'b000, bus1.timeout}, {3'b000, m[1].to});
        if (m[1].busy) checkOutput("m1.owner", {2'b00, bus1.owner}, 4'(m[1].owner));
      end
    end
  end

  initial begin
    tbReq[0] = 4'b0000; tbReq[1] = 4'b0000;
    tbEn[0] = 1'b1; tbEn[1] = 1'b1;
    expRot = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0010,
               4'b0000, 4'b0001, 4'b0000, 4'b1000};
    @(negedge Clk);
    checkOutput("reset.gate", bus0.gate, 4'b0000);
    checkOutput("reset.busy", {3'b000, bus0.busy}, 4'b0000);
    checkOutput("reset.timeout", {3'b000, bus0.timeout}, 4'b0000);
    checkOutput("reset.owner", {2'b00, bus0.owner}, 4'b0000);

    $display("[TB] single ALU request held three cycles");
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0010, 1'b1);
      checkOutput("alu.gate0", bus0.gate, 4'b0010);
      checkOutput("alu.owner0", {2'b00, bus0.owner}, 4'b0001);
      checkOutput("alu.busy0", {3'b000, bus0.busy}, 4'b0001);
      checkOutput("alu.gate1", bus1.gate, 4'b0010);
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("alu.turn0", bus0.gate, 4'b0000);
    checkOutput("alu.idle1", bus1.gate, 4'b0000);
    applyStimulus(4'b0000, 1'b1);

    $display("[TB] round robin with all four requesting");
    doReset();
    tbReq[0] = 4'b1111; tbReq[1] = 4'b1111;
    @(negedge Clk);
    for (int i = 0; i < 9; i++) begin
      gotRot[i] = bus0.gate;
      tbReq[0] = 4'b1111 & ~bus0.gate;
      tbReq[1] = 4'b1111 & ~bus1.gate;
      @(negedge Clk);
    end
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("rot.step%0d", i), gotRot[i], expRot[i]);
    end
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    $display("[TB] MDR holds request until the hold limit");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0001, 1'b1);
      checkOutput("hold.gate0", bus0.gate, 4'b0001);
      checkOutput("hold.to0", {3'b000, bus0.timeout}, 4'b0000);
    end
    applyStimulus(4'b0001, 1'b1);
    checkOutput("expire.gate0", bus0.gate, 4'b0000);
    checkOutput("expire.to0", {3'b000, bus0.timeout}, 4'b0001);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("regrant.gate0", bus0.gate, 4'b0001);
    checkOutput("regrant.to0", {3'b000, bus0.timeout}, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 1'b1);
    checkOutput("expire.gate1", bus1.gate, 4'b0000);
    checkOutput("expire.to1", {3'b000, bus1.timeout}, 4'b0001);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("regrant.gate1", bus1.gate, 4'b0001);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    $display("[TB] direct handoff from PC to ALU");
    doReset();
    applyStimulus(4'b0110, 1'b1);
    checkOutput("hand.pc1", bus1.gate, 4'b0100);
    checkOutput("hand.pc0", bus0.gate, 4'b0100);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("hand.alu1", bus1.gate, 4'b0010);
    checkOutput("hand.gap0", bus0.gate, 4'b0000);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("hand.alu0", bus0.gate, 4'b0010);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    $display("[TB] arb_en gating of new grants");
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1000, 1'b0);
      checkOutput("en.blocked0", bus0.gate, 4'b0000);
    end
    applyStimulus(4'b1000, 1'b1);
    checkOutput("en.grant0", bus0.gate, 4'b1000);
    checkOutput("en.grant1", bus1.gate, 4'b1000);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("en.release0", bus0.gate, 4'b0000);

    $display("[TB] hold limit still fires with arb_en low");
    doReset();
    applyStimulus(4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 1'b0);
    checkOutput("enlow.held0", bus0.gate, 4'b0001);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("enlow.to0", {3'b000, bus0.timeout}, 4'b0001);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("enlow.nogrant0", bus0.gate, 4'b0000);
    applyStimulus(4'b0000, 1'b1);

    $display("[TB] asynchronous reset during a grant");
    doReset();
    applyStimulus(4'b0100, 1'b1);
    checkOutput("areset.pre0", bus0.gate, 4'b0100);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("areset.gate0", bus0.gate, 4'b0000);
    checkOutput("areset.busy0", {3'b000, bus0.busy}, 4'b0000);
    checkOutput("areset.gate1", bus1.gate, 4'b0000);
    @(negedge Clk);
    Reset_n = 1'b1;
    tbReq[0] = 4'b1111; tbReq[1] = 4'b1111;
    @(negedge Clk);
    checkOutput("areset.first0", bus0.gate, 4'b1000);
    checkOutput("areset.first1", bus1.gate, 4'b1000);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/bus_gate_arbiter.md
Name: bus_gate_arbiter

Overview:
- Sequences ownership of the shared 16-bit datapath bus among its four sources: MARMUX, PC, ALU, MDR.
- Produces the registered one-hot gate vector {GateMARMUX, GatePC, GateALU, GateMDR} that selects the bus-mux input.
- Uses round-robin arbitration, a bounded hold time per grant, and an optional dead (turnaround) cycle between owners.
- Sits between the per-source request logic and the bus mux, replacing hard-wired gate decode.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one owner may hold the bus. 0 disables the timeout.
- CNT_W, default 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.
- TURNAROUND, default 1: 1 forces one all-zero gate cycle between owners; 0 allows a direct handoff.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- arb_en  input  1  1 allows new grants; 0 blocks new grants but lets the current grant run to release or timeout.
- req  input  4  bus requests, bit order {MARMUX, PC, ALU, MDR} (bit3..bit0).
- gate  output  4  registered one-hot gate to the bus mux, same bit order; 4'b0000 means no driver.
- owner  output  2  index of the current owner (3=MARMUX .. 0=MDR). Valid only while busy=1.
- busy  output  1  1 while any gate bit is set.
- timeout  output  1  one-cycle pulse, asserted in the first cycle after a forced release.

Behaviour:
- Reset (async assert, sync deassert by Clk):
  - gate=0, owner=0, busy=0, timeout=0.
  - Internal: state=IDLE, hold_cnt=0, priority pointer ptr=3.
- States: IDLE, GRANT, TURN. TURN exists only when TURNAROUND=1.
- Arbitration (combinational pick, registered result):
  - Search order is ptr, ptr-1, ..., wrapping 0->3.
  - First index with req=1 wins. Example: ptr=3 gives order 3,2,1,0; ptr=0 gives 0,3,2,1.
- IDLE:
  - If arb_en=1 and req!=0 at edge t: gate=onehot(winner) and owner=winner from t+1; hold_cnt=1; go to GRANT.
  - Otherwise gate stays 0.
- GRANT, owner releases (req[owner]=0 at edge):
  - gate clears at the next cycle.
  - ptr=owner-1 mod 4, so the released owner becomes lowest priority.
  - Go to TURN if TURNAROUND=1.
  - If TURNAROUND=0, arbitrate in the same edge using the new ptr, excluding the old owner:
    - winner present and arb_en=1: gate switches directly to the new one-hot, hold_cnt=1, stay in GRANT;
    - otherwise go to IDLE.
- GRANT, timeout (MAX_HOLD!=0, hold_cnt==MAX_HOLD, req[owner] still 1):
  - Same as release, and additionally timeout=1 for exactly one cycle.
  - The old owner is excluded only from the arbitration at this edge. It may be re-granted later per the rotated ptr.
- GRANT otherwise: hold_cnt increments with saturation at 2^CNT_W-1. gate stays stable.
- TURN: gate=0 for exactly one cycle, then act as IDLE at the next edge.
- arb_en=0: never blocks a release, and it does not block the timeout pulse.
- Invariants:
  - gate is always one-hot or zero; never two bits set.
  - busy==|gate.
  - gate is glitch-free because it comes straight from a register.
- Latency: request-to-gate is 1 cycle from IDLE. Handoff gap is 1 zero cycle (TURNAROUND=1) or 0 cycles (TURNAROUND=0).
- Simultaneous events:
  - Release and timeout on the same edge count as a release only (no timeout pulse).
  - New requests arriving while in GRANT wait. Requests that drop before being granted are simply not granted.
- Reset mid-grant: gate drops to 0 immediately (async). No timeout pulse.

Test Plan:
- Reset, then req=4'b0010 held 3 cycles and dropped:
  - gate=0010 starting the cycle after req is sampled, for 3 cycles;
  - owner=1, busy=1 during the grant;
  - with TURNAROUND=1, gate=0000 for the TURN cycle before IDLE.
- From reset (ptr=3), req=4'b1111 with each owner dropping req right after its grant:
  - grant order is 1000, 0100, 0010, 0001, 1000;
  - with TURNAROUND=1, one zero cycle between each grant.
- MAX_HOLD=4, req=4'b0001 held forever:
  - gate=0001 for exactly 4 cycles, then 0000 with timeout=1 for one cycle;
  - re-grant of 0001 follows after TURN.
- TURNAROUND=0, req=4'b0110, owner PC drops req:
  - gate goes 0100 -> 0010 on consecutive cycles with no zero cycle.
- arb_en=0 with req=4'b1000 -> gate stays 0000. Raising arb_en to 1 -> gate=1000 on the next cycle.
- Reset_n pulled low while gate=0100:
  - gate=0000, busy=0 immediately, asynchronous to Clk;
  - after release, req=1111 grants 1000 first (ptr back at 3).
